// File: rtl/mem_test_pkg.sv
// Shared types and constants for the memory test responder.
// Defaults for widths, refresh FSM states and the test pattern.
package mem_test_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 16;

  localparam logic [15:0] TEST_PATTERN = 16'h5555;

  typedef enum logic {
    ST_NORMAL  = 1'b0,
    ST_REFRESH = 1'b1
  } refresh_state_e;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc(
    input logic [15:0] v
  );
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/mem_resp_rdpipe.sv
// Read-latency shift pipeline: valid bit plus data, RD_LAT stages.
// Data in each stage only moves when a valid word moves into it.
module mem_resp_rdpipe #(
  parameter int RD_LAT = 2,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_vld,
  input  logic [DATA_W-1:0] in_dat,
  output logic              out_vld,
  output logic [DATA_W-1:0] out_dat
);

  logic [RD_LAT-1:0] vld_q;
  logic [RD_LAT-1:0] vld_d;
  logic [DATA_W-1:0] dat_q [RD_LAT];
  logic [DATA_W-1:0] dat_d [RD_LAT];

  // Shift valid every cycle; hold data unless a valid word arrives.
  always_comb begin
    vld_d = vld_q;
    for (int i = 0; i < RD_LAT; i++) begin
      dat_d[i] = dat_q[i];
    end
    vld_d[0] = in_vld;
    if (in_vld) begin
      dat_d[0] = in_dat;
    end
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      if (vld_q[i-1]) begin
        dat_d[i] = dat_q[i-1];
      end
    end
  end

  // Pipeline registers; reset discards reads in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        dat_q[i] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      for (int i = 0; i < RD_LAT; i++) begin
        dat_q[i] <= dat_d[i];
      end
    end
  end

  assign out_vld = vld_q[RD_LAT-1];
  assign out_dat = dat_q[RD_LAT-1];

endmodule

// File: rtl/mem_test_responder.sv
// Memory-mapped test responder with pipelined reads and refresh stalls.
// Refresh FSM built only when MEM_TEST_RESPONDER_REFRESH_EN is defined.
module mem_test_responder
  import mem_test_pkg::*;
#(
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int RD_LAT         = 2,
  parameter int REFRESH_PERIOD = 64,
  parameter int REFRESH_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write,
  input  logic              read,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] readdata,
  output logic              readdatavalid,
  output logic              waitrequest,
  output logic [15:0]       wr_cnt,
  output logic [15:0]       rd_cnt,
  output logic              err
);

  if (RD_LAT < 1 || RD_LAT > 8) begin : g_bad_lat
    $error("RD_LAT out of range");
  end
  if (REFRESH_PERIOD < 4) begin : g_bad_per
    $error("REFRESH_PERIOD too small");
  end
  if (REFRESH_CYCLES < 1 || REFRESH_CYCLES >= REFRESH_PERIOD) begin : g_bad_cyc
    $error("REFRESH_CYCLES out of range");
  end

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic        wreq;
  logic        accept;
  logic        do_wr;
  logic        do_rd;
  logic        rw_clash;
  logic [15:0] wr_cnt_q, wr_cnt_d;
  logic [15:0] rd_cnt_q, rd_cnt_d;
  logic        err_q, err_d;

  assign accept   = (read | write) & ~wreq;
  assign do_wr    = accept & write;
  assign do_rd    = accept & read & ~write;
  assign rw_clash = accept & read & write;

  // Memory array: written on accept, never cleared by reset.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[address] <= writedata;
    end
  end

  // Saturating command counters and sticky clash flag.
  always_comb begin
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    err_d    = err_q | rw_clash;
    if (do_wr) begin
      wr_cnt_d = sat_inc(wr_cnt_q);
    end
    if (do_rd) begin
      rd_cnt_d = sat_inc(rd_cnt_q);
    end
  end

  // Counter and flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      err_q    <= err_d;
    end
  end

  mem_resp_rdpipe #(
    .RD_LAT (RD_LAT),
    .DATA_W (DATA_W)
  ) u_rdpipe (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (do_rd),
    .in_dat  (mem_q[address]),
    .out_vld (readdatavalid),
    .out_dat (readdata)
  );

`ifdef MEM_TEST_RESPONDER_REFRESH_EN
  localparam int CNT_W = $clog2(REFRESH_PERIOD);

  refresh_state_e   state_q, state_d;
  logic [CNT_W-1:0] rcnt_q, rcnt_d;
  logic             wreq_q, wreq_d;

  // Next state: count NORMAL cycles, then stall for the refresh window.
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    wreq_d  = wreq_q;
    unique case (state_q)
      ST_NORMAL: begin
        if (rcnt_q == CNT_W'(REFRESH_PERIOD - 1)) begin
          state_d = ST_REFRESH;
          rcnt_d  = '0;
          wreq_d  = 1'b1;
        end else begin
          rcnt_d = rcnt_q + CNT_W'(1);
        end
      end
      ST_REFRESH: begin
        if (rcnt_q == CNT_W'(REFRESH_CYCLES - 1)) begin
          state_d = ST_NORMAL;
          rcnt_d  = '0;
          wreq_d  = 1'b0;
        end else begin
          rcnt_d = rcnt_q + CNT_W'(1);
        end
      end
    endcase
  end

  // Refresh FSM registers; waitrequest comes straight from a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_NORMAL;
      rcnt_q  <= '0;
      wreq_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      wreq_q  <= wreq_d;
    end
  end

  assign wreq = wreq_q;
`else
  assign wreq = 1'b0;
`endif

  assign waitrequest = wreq;
  assign wr_cnt      = wr_cnt_q;
  assign rd_cnt      = rd_cnt_q;
  assign err         = err_q;

endmodule

// File: tb/tb_mem_test_responder.sv
// Self-checking bench for mem_test_responder (default parameters).
// Directed table, sweeps, random traffic vs a cycle-level reference model.
module tb_mem_test_responder;
  import mem_test_pkg::*;

  localparam int AW  = 8;
  localparam int DW  = 16;
  localparam int LAT = 2;
  localparam int RP  = 64;
  localparam int RC  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          write = 1'b0;
  logic          read = 1'b0;
  logic [AW-1:0] address = '0;
  logic [DW-1:0] writedata = '0;
  logic [DW-1:0] readdata;
  logic          readdatavalid;
  logic          waitrequest;
  logic [15:0]   wr_cnt;
  logic [15:0]   rd_cnt;
  logic          err;

  mem_test_responder dut (
    .clk           (clk),
    .rst           (rst),
    .write         (write),
    .read          (read),
    .address       (address),
    .writedata     (writedata),
    .readdata      (readdata),
    .readdatavalid (readdatavalid),
    .waitrequest   (waitrequest),
    .wr_cnt        (wr_cnt),
    .rd_cnt        (rd_cnt),
    .err           (err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state
  typedef struct {
    int          due;
    logic [15:0] d;
  } pend_t;

  logic [15:0] m_mem [256];
  pend_t       pq [$];
  int          cyc;
  logic [15:0] m_wr;
  logic [15:0] m_rd;
  bit          m_err;
  logic [15:0] m_last;

  // Outputs sampled inside the latest step
  logic        s_rdv;
  logic [15:0] s_rdata;
  logic        s_err;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                 nm, act, exp, cyc);
    end
  endtask

  // Refresh windows repeat every RP+RC cycles, starting at cycle RP.
  function automatic bit exp_wreq(input int c);
    bit r;
    r = 1'b0;
`ifdef MEM_TEST_RESPONDER_REFRESH_EN
    r = (c >= RP) && (((c - RP) % (RP + RC)) < RC);
`endif
    return r;
  endfunction

  function automatic logic [15:0] sat(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // One clock cycle: drive, check against model, advance model.
  task automatic step(input bit rd, input bit wr, input logic [7:0] a,
                      input logic [15:0] d, output bit acc);
    bit er;
    read = rd;
    write = wr;
    address = a;
    writedata = d;
    #1;
    er = 1'b0;
    if (pq.size() > 0 && pq[0].due == cyc) begin
      er = 1'b1;
      m_last = pq[0].d;
      void'(pq.pop_front());
    end
    s_rdv   = readdatavalid;
    s_rdata = readdata;
    s_err   = err;
    chk("waitrequest", waitrequest, exp_wreq(cyc));
    chk("readdatavalid", readdatavalid, er);
    chk("readdata", readdata, m_last);
    chk("wr_cnt", wr_cnt, m_wr);
    chk("rd_cnt", rd_cnt, m_rd);
    chk("err", err, m_err);
    acc = (rd | wr) && !exp_wreq(cyc);
    @(posedge clk);
    if (acc) begin
      if (wr) begin
        m_mem[a] = d;
        m_wr = sat(m_wr);
        if (rd) m_err = 1'b1;
      end else begin
        pq.push_back('{cyc + LAT, m_mem[a]});
        m_rd = sat(m_rd);
      end
    end
    cyc++;
    #2;
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(0, 0, 8'h00, 16'h0, acc);
  endtask

  // Hold a command until accepted, bounded.
  task automatic cmd(input bit rd, input bit wr, input logic [7:0] a,
                     input logic [15:0] d);
    bit acc;
    int tries;
    tries = 0;
    acc = 1'b0;
    while (!acc && tries < 20) begin
      step(rd, wr, a, d, acc);
      tries++;
    end
    chk("accept_timeout", {31'd0, acc}, 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    read = 1'b0;
    write = 1'b0;
    #1;
    chk("rst_readdata", readdata, 0);
    chk("rst_rdv", readdatavalid, 0);
    chk("rst_wreq", waitrequest, 0);
    chk("rst_wr_cnt", wr_cnt, 0);
    chk("rst_rd_cnt", rd_cnt, 0);
    chk("rst_err", err, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    pq.delete();
    m_wr = 0;
    m_rd = 0;
    m_err = 1'b0;
    m_last = 0;
  endtask

  typedef struct {
    bit          rd;
    bit          wr;
    logic [7:0]  a;
    logic [15:0] d;
    bit          rdv;
    logic [15:0] rdata;
    bit          err;
  } vec_t;

  vec_t tbl [11];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int c0;
    int acc_cyc;
    int npulse;
    tbl[0]  = '{0, 1, 8'h00, TEST_PATTERN, 0, 16'h0000, 0};
    tbl[1]  = '{1, 0, 8'h00, 16'h0000, 0, 16'h0000, 0};
    tbl[2]  = '{0, 1, 8'hFF, 16'hBEEF, 0, 16'h0000, 0};
    tbl[3]  = '{1, 0, 8'hFF, 16'h0000, 1, 16'h5555, 0};
    tbl[4]  = '{0, 1, 8'h20, 16'h1234, 0, 16'h5555, 0};
    tbl[5]  = '{1, 0, 8'h20, 16'h0000, 1, 16'hBEEF, 0};
    tbl[6]  = '{1, 1, 8'h10, 16'hAAAA, 0, 16'hBEEF, 0};
    tbl[7]  = '{1, 0, 8'h10, 16'h0000, 1, 16'h1234, 1};
    tbl[8]  = '{0, 0, 8'h00, 16'h0000, 0, 16'h1234, 1};
    tbl[9]  = '{0, 0, 8'h00, 16'h0000, 1, 16'hAAAA, 1};
    tbl[10] = '{0, 0, 8'h00, 16'h0000, 0, 16'hAAAA, 1};

    do_reset();

    // Directed table: pattern, max address, RAW, read/write clash
    for (int i = 0; i < 11; i++) begin
      step(tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].d, acc);
      chk($sformatf("tbl%0d_rdv", i), s_rdv, tbl[i].rdv);
      chk($sformatf("tbl%0d_rdata", i), s_rdata, tbl[i].rdata);
      chk($sformatf("tbl%0d_err", i), s_err, tbl[i].err);
    end

    // Refresh window timing from reset, held read during window
    do_reset();
    idle(62);
    c0 = cyc;
    acc = 1'b0;
    acc_cyc = -1;
    while (!acc && cyc < c0 + 20) begin
      acc_cyc = cyc;
      step(1, 0, 8'hFF, 16'h0, acc);
    end
`ifdef MEM_TEST_RESPONDER_REFRESH_EN
    chk("held_read_accept_cycle", acc_cyc, 68);
`else
    chk("held_read_accept_cycle", acc_cyc, 62);
`endif
    idle(8);

    // Full sweep: write every address, then back-to-back reads
    do_reset();
    for (int a = 0; a < 256; a++) cmd(0, 1, 8'(a), 16'(a));
    npulse = 0;
    for (int a = 0; a < 256; a++) begin
      acc = 1'b0;
      while (!acc) begin
        step(1, 0, 8'(a), 16'h0, acc);
        if (s_rdv) npulse++;
      end
    end
    for (int i = 0; i < LAT + 2; i++) begin
      step(0, 0, 8'h00, 16'h0, acc);
      if (s_rdv) npulse++;
    end
    chk("sweep_pulses", npulse, 256);
    chk("sweep_wr_cnt", wr_cnt, 256);
    chk("sweep_rd_cnt", rd_cnt, 256);
    chk("sweep_last_data", readdata, 16'h00FF);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic [1:0] r;
      r = 2'($urandom_range(0, 3));
      step(r[0], r[1] & ($urandom_range(0, 3) == 0), 8'($urandom),
           16'($urandom), acc);
    end
    idle(LAT + 1);

    // Read in flight when reset hits
    cmd(1, 0, 8'h33, 16'h0);
    rst = 1'b1;
    #1;
    chk("flight_rdv", readdatavalid, 0);
    chk("flight_readdata", readdata, 0);
    chk("flight_wr_cnt", wr_cnt, 0);
    chk("flight_rd_cnt", rd_cnt, 0);
    chk("flight_err", err, 0);
    do_reset();
    npulse = 0;
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 8'h00, 16'h0, acc);
      if (s_rdv) npulse++;
    end
    chk("flight_no_pulse", npulse, 0);

    // Write counter saturation
    do_reset();
    while (m_wr != 16'hFFFE) cmd(0, 1, 8'($urandom), 16'($urandom));
    chk("sat_pre", wr_cnt, 16'hFFFE);
    for (int i = 0; i < 3; i++) cmd(0, 1, 8'h44, 16'(i));
    chk("sat_post", wr_cnt, 16'hFFFF);
    idle(3);
    chk("sat_hold", wr_cnt, 16'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_test_responder.md
MEM_TEST_RESPONDER -- requirements
Module: mem_test_responder

Interface
REQ-001 Parameter ADDR_W, default 8, address width; internal array depth 2**ADDR_W words SHALL be provided.
REQ-002 Parameter DATA_W, default 16, data word width.
REQ-003 Parameter RD_LAT, default 2, accept-to-readdatavalid latency in clk cycles; legal range 1..8.
REQ-004 Parameter REFRESH_PERIOD, default 64, NORMAL-state cycles between refresh windows; legal range >= 4.
REQ-005 Parameter REFRESH_CYCLES, default 4, waitrequest-high cycles per refresh window; legal range 1..REFRESH_PERIOD-1.
REQ-006 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 write  input  1  write strobe from the initiator.
REQ-009 read  input  1  read strobe from the initiator.
REQ-010 address  input  ADDR_W  word address.
REQ-011 writedata  input  DATA_W  write data.
REQ-012 readdata  output  DATA_W  read return data, registered.
REQ-013 readdatavalid  output  1  one-cycle pulse per returned read.
REQ-014 waitrequest  output  1  registered; high means the command is not accepted this cycle.
REQ-015 wr_cnt  output  16  accepted writes, saturating at 16'hFFFF.
REQ-016 rd_cnt  output  16  accepted reads, saturating at 16'hFFFF.
REQ-017 err  output  1  sticky flag, set on a simultaneous read and write.

Function
REQ-018 A command SHALL be accepted on a rising edge where (read|write) && !waitrequest; strobes held while waitrequest=1 SHALL be ignored, and the initiator SHALL hold them.
REQ-019 An accepted write SHALL store writedata into mem[address] on the accept edge.
REQ-020 An accepted read SHALL sample mem[address] on the accept edge; readdata and a readdatavalid pulse SHALL appear exactly RD_LAT cycles after the accept edge.
REQ-021 Back-to-back reads, one per cycle, SHALL be fully pipelined; return order SHALL equal accept order, with no bubbles added.
REQ-022 readdata SHALL hold its last returned value while readdatavalid=0.
REQ-023 A read accepted the cycle after a write to the same address SHALL return the new data.
REQ-024 When read=write=1 at acceptance, the write SHALL be performed, the read SHALL be dropped (no readdatavalid, rd_cnt unchanged), and err SHALL set.
REQ-025 wr_cnt and rd_cnt SHALL each increment by 1 per accepted command and SHALL stick at 16'hFFFF.
REQ-026 Refresh FSM states: NORMAL and REFRESH.
REQ-027 In NORMAL, the refresh counter SHALL increment every cycle; after REFRESH_PERIOD cycles the FSM SHALL move to REFRESH.
REQ-028 In REFRESH, waitrequest SHALL be 1 for exactly REFRESH_CYCLES cycles; the FSM SHALL then return to NORMAL with the counter at 0.
REQ-029 Reads accepted before a refresh window SHALL still return at their scheduled cycle during REFRESH.
REQ-030 The address SHALL be used modulo 2**ADDR_W; address all-ones SHALL be a valid location, and there SHALL be no wrap side effects.

Reset
REQ-031 rst SHALL force readdata=0, readdatavalid=0, waitrequest=0, wr_cnt=0, rd_cnt=0, err=0, FSM=NORMAL and refresh counter=0.
REQ-032 rst SHALL clear the read pipeline; reads in flight SHALL be discarded and SHALL produce no readdatavalid after reset.
REQ-033 Memory contents SHALL NOT be cleared by rst; contents after power-up are undefined.

Configuration
REQ-034 With macro MEM_TEST_RESPONDER_REFRESH_EN defined, the refresh FSM of REQ-026..029 SHALL be active.
REQ-035 Without MEM_TEST_RESPONDER_REFRESH_EN, the refresh FSM and counter SHALL be compiled out and waitrequest SHALL be tied to 0.

Structure
REQ-036 Shared package mem_test_pkg SHALL hold the default ADDR_W/DATA_W, the refresh state enum, and the test pattern constant 16'h5555.
REQ-037 The read-latency shift pipeline (valid bit plus data) SHALL be the sub-module mem_resp_rdpipe, parameterised by RD_LAT and DATA_W.

Verification
REQ-038 Write 16'h5555 at address 8'h00, then read 8'h00 (RD_LAT=2) -> readdatavalid pulses 2 cycles after read accept with readdata=16'h5555.
REQ-039 Write addresses 0..255 with data=address, then 256 back-to-back reads -> 256 consecutive readdatavalid pulses with readdata=0..255 in order; wr_cnt=rd_cnt=256.
REQ-040 With refresh enabled and defaults, idle from reset -> waitrequest high on cycles 64..67, then low; a read held during the window is accepted on the first cycle with waitrequest=0.
REQ-041 read=write=1 at address 8'h10 with writedata 16'hAAAA -> mem[16'h10]=16'hAAAA, no readdatavalid, err=1 until rst.
REQ-042 Read accepted, then rst asserted 1 cycle later -> no readdatavalid, and all outputs equal their REQ-031 values.
REQ-043 Force wr_cnt to 16'hFFFE, then issue 3 writes -> wr_cnt=16'hFFFF.
